// File: rtl/key_filter_array.sv
// -----------------------------------------------------------------------------
// key_filter_array
//   N-channel push-button conditioner for raw active-low board keys.
//   Each channel: 2-flop synchroniser -> stability-counter debouncer with
//   press/release pulses -> optional hold-to-repeat generator.
//   A priority encoder reports the lowest-numbered key_press bit.
//
// Build option:
//   KEY_AUTOREPEAT_EN  when defined, a key held in HELD emits a repeat press
//                      HOLD_CYC clocks after the initial press, then one every
//                      REPEAT_CYC clocks. When undefined, no repeat hardware
//                      exists and HOLD_CYC / REPEAT_CYC only size the counters.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_n        raw keys, asynchronous, 0 = pressed
//   key_state    debounced level, 1 = pressed
//   key_press    one-cycle pulse per accepted press and per repeat tick
//   key_release  one-cycle pulse per accepted release
//   key_valid    key_press is non-zero this cycle
//   key_code     index of lowest set key_press bit, 0 when key_valid low
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// key_filter_lane
//   One channel of the array.
//   clk, rst_n   clock / async active-low reset
//   key_n_i      raw key, 0 = pressed
//   state_o      debounced level
//   press_o      press / repeat pulse
//   release_o    release pulse
// -----------------------------------------------------------------------------
module key_filter_lane #(
   parameter int DEBOUNCE_CYC = 1000000,
`ifdef KEY_AUTOREPEAT_EN
   parameter int HOLD_CYC     = 25000000,
   parameter int REPEAT_CYC   = 5000000,
`endif
   parameter int CNT_W        = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n_i,
   output logic state_o,
   output logic press_o,
   output logic release_o
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_PRESS_DB = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;
   localparam logic [1:0] ST_REL_DB   = 2'd3;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   // Saturating increment: counters stop at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // sync_q[0] is the metastability flop, sync_q[1] the stable sample.
   logic [1:0]       sync_q, sync_d;
   logic [1:0]       st_q, st_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic             state_q, state_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             pressed;
   logic             rpt_pulse;

   assign pressed = ~sync_q[1];

`ifdef KEY_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

   // rpt_act_q: the initial hold delay has expired and the channel is in
   // the periodic phase. Counters only advance while HELD with the key
   // still pressed, so a release-bounce (REL_DB) freezes them, and they are
   // cleared once the channel is back in IDLE.
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_act_q, rpt_act_d;

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      rpt_cnt_d  = rpt_cnt_q;
      rpt_act_d  = rpt_act_q;
      rpt_pulse  = 1'b0;
      if (st_q == ST_IDLE) begin
         hold_cnt_d = '0;
         rpt_cnt_d  = '0;
         rpt_act_d  = 1'b0;
      end else if (st_q == ST_HELD && pressed) begin
         if (!rpt_act_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
               rpt_pulse = 1'b1;
               rpt_act_d = 1'b1;
               rpt_cnt_d = '0;
            end else begin
               hold_cnt_d = sat_inc(hold_cnt_q);
            end
         end else begin
            if (rpt_cnt_q == REP_LAST) begin
               rpt_pulse = 1'b1;
               rpt_cnt_d = '0;
            end else begin
               rpt_cnt_d = sat_inc(rpt_cnt_q);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
         rpt_cnt_q  <= '0;
         rpt_act_q  <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         rpt_cnt_q  <= rpt_cnt_d;
         rpt_act_q  <= rpt_act_d;
      end
   end
`else
   assign rpt_pulse = 1'b0;
`endif

   always_comb begin
      sync_d    = {sync_q[0], key_n_i};
      st_d      = st_q;
      db_cnt_d  = db_cnt_q;
      state_d   = state_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (pressed) begin
               db_cnt_d = '0;
               st_d     = ST_PRESS_DB;
            end
         end
         ST_PRESS_DB: begin
            // Any released sample before the count completes is a bounce.
            if (!pressed) begin
               st_d = ST_IDLE;
            end else if (db_cnt_q == DB_LAST) begin
               st_d    = ST_HELD;
               state_d = 1'b1;
               press_d = 1'b1;
            end else begin
               db_cnt_d = sat_inc(db_cnt_q);
            end
         end
         ST_HELD: begin
            if (!pressed) begin
               db_cnt_d = '0;
               st_d     = ST_REL_DB;
            end else begin
               press_d = rpt_pulse;
            end
         end
         ST_REL_DB: begin
            // Returning to HELD is silent; the repeat state is untouched.
            if (pressed) begin
               st_d = ST_HELD;
            end else if (db_cnt_q == DB_LAST) begin
               st_d      = ST_IDLE;
               state_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               db_cnt_d = sat_inc(db_cnt_q);
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   // Synchroniser resets to "released" so a key held through reset is
   // debounced from the first clock after reset like a fresh press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         st_q      <= ST_IDLE;
         db_cnt_q  <= '0;
         state_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         st_q      <= st_d;
         db_cnt_q  <= db_cnt_d;
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign state_o   = state_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

module key_filter_array #(
   parameter int NUM_KEYS     = 4,
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int HOLD_CYC     = 25000000,
   parameter int REPEAT_CYC   = 5000000
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [NUM_KEYS-1:0]                           key_n,
   output logic [NUM_KEYS-1:0]                           key_state,
   output logic [NUM_KEYS-1:0]                           key_press,
   output logic [NUM_KEYS-1:0]                           key_release,
   output logic                                          key_valid,
   output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] key_code
);

   localparam int KC_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int MAX_DH  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
   localparam int MAX_ALL = (MAX_DH > REPEAT_CYC) ? MAX_DH : REPEAT_CYC;
   localparam int CNT_W   = ($clog2(MAX_ALL) < 1) ? 1 : $clog2(MAX_ALL);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
      key_filter_lane #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
`ifdef KEY_AUTOREPEAT_EN
         .HOLD_CYC     (HOLD_CYC),
         .REPEAT_CYC   (REPEAT_CYC),
`endif
         .CNT_W        (CNT_W)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .key_n_i   (key_n[g]),
         .state_o   (key_state[g]),
         .press_o   (key_press[g]),
         .release_o (key_release[g])
      );
   end

   // Scan from the top down so the lowest set index is the one that sticks.
   always_comb begin
      key_code = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (key_press[i]) key_code = KC_W'(i);
      end
   end

   assign key_valid = |key_press;

endmodule

// File: tb/tb_key_filter_array.sv
module tb_key_filter_array;

   logic       clk;
   logic       rst_n;
   logic [3:0] key_n;
   logic [3:0] key_state, key_press, key_release;
   logic       key_valid;
   logic [1:0] key_code;

   int n_chk = 0;
   int n_err = 0;

   key_filter_array #(
      .NUM_KEYS     (4),
      .DEBOUNCE_CYC (16),
      .HOLD_CYC     (64),
      .REPEAT_CYC   (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_valid   (key_valid),
      .key_code    (key_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] key_n;
      int         cycles;
      logic [3:0] press;
      logic [1:0] code;
      int         p0, p1, p2;
      logic [3:0] rel;
      int         r0;
      logic [3:0] st_pre;
      logic [3:0] st_post;
      int         st_at;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_now(input string tag, input logic [3:0] ep, input logic [1:0] ec,
                            input logic [3:0] er, input logic [3:0] es);
      chk({tag, " press"},   32'(key_press),   32'(ep));
      chk({tag, " release"}, 32'(key_release), 32'(er));
      chk({tag, " valid"},   32'(key_valid),   32'(ep != 4'b0000));
      chk({tag, " code"},    32'(key_code),    32'(ec));
      chk({tag, " state"},   32'(key_state),   32'(es));
   endtask

   // Drive key_n, then check every cycle k (k = 0 is the next rising edge).
   task automatic run(input string tag, input vec_t v);
      logic [3:0] ep, er, es;
      logic [1:0] ec;
      key_n = v.key_n;
      for (int k = 0; k < v.cycles; k++) begin
         @(posedge clk);
         #1;
         ep = (k == v.p0 || k == v.p1 || k == v.p2) ? v.press : 4'b0000;
         ec = (ep != 4'b0000) ? v.code : 2'd0;
         er = (k == v.r0) ? v.rel : 4'b0000;
         es = (v.st_at >= 0 && k >= v.st_at) ? v.st_post : v.st_pre;
         check_now($sformatf("%s c%0d", tag, k), ep, ec, er, es);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      vec_t v;
      int   rp1, rp2;
`ifdef KEY_AUTOREPEAT_EN
      rp1 = 82; rp2 = 98;
`else
      rp1 = -1; rp2 = -1;
`endif
      //           key_n   cyc  press    code  p0  p1   p2   rel      r0  pre      post     at
      vecs[0] = '{4'b1110, 40, 4'b0001, 2'd0, 18, -1,  -1,  4'b0000, -1, 4'b0000, 4'b0001, 18};
      vecs[1] = '{4'b1111, 30, 4'b0000, 2'd0, -1, -1,  -1,  4'b0001, 18, 4'b0001, 4'b0000, 18};
      vecs[2] = '{4'b0011, 30, 4'b1100, 2'd2, 18, -1,  -1,  4'b0000, -1, 4'b0000, 4'b1100, 18};
      vecs[3] = '{4'b1111, 30, 4'b0000, 2'd0, -1, -1,  -1,  4'b1100, 18, 4'b1100, 4'b0000, 18};
      vecs[4] = '{4'b1011, 100, 4'b0100, 2'd2, 18, rp1, rp2, 4'b0000, -1, 4'b0000, 4'b0100, 18};
      vecs[5] = '{4'b1111, 30, 4'b0000, 2'd0, -1, -1,  -1,  4'b0100, 18, 4'b0100, 4'b0000, 18};

      // Reset state
      rst_n = 1'b0;
      key_n = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      check_now("reset", 4'b0000, 2'd0, 4'b0000, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Clean press, simultaneous press, auto-repeat
      for (int i = 0; i < 6; i++) run($sformatf("vec%0d", i), vecs[i]);

      // Bounce: 1101/1111 every 5 cycles, never long enough to accept
      for (int t = 0; t < 60; t++) begin
         key_n = (((t / 5) % 2) == 0) ? 4'b1101 : 4'b1111;
         @(posedge clk);
         #1;
         check_now($sformatf("bounce c%0d", t), 4'b0000, 2'd0, 4'b0000, 4'b0000);
      end
      v = '{4'b1111, 20, 4'b0000, 2'd0, -1, -1, -1, 4'b0000, -1, 4'b0000, 4'b0000, -1};
      run("bounce end", v);

      // Reset mid-press: key 1 reaches HELD, then reset for 3 cycles
      v = '{4'b1101, 20, 4'b0010, 2'd1, 18, -1, -1, 4'b0000, -1, 4'b0000, 4'b0010, 18};
      run("pre-rst", v);
      #1;
      rst_n = 1'b0;
      #1;
      check_now("rst async", 4'b0000, 2'd0, 4'b0000, 4'b0000);
      for (int t = 0; t < 3; t++) begin
         @(posedge clk);
         #1;
         check_now($sformatf("rst low c%0d", t), 4'b0000, 2'd0, 4'b0000, 4'b0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      v = '{4'b1101, 26, 4'b0010, 2'd1, 18, -1, -1, 4'b0000, -1, 4'b0000, 4'b0010, 18};
      run("post-rst", v);

      // Release-bounce: 8 released cycles inside HELD are rejected
      v = '{4'b1111, 8, 4'b0000, 2'd0, -1, -1, -1, 4'b0000, -1, 4'b0010, 4'b0010, -1};
      run("relb off", v);
      v = '{4'b1101, 30, 4'b0000, 2'd0, -1, -1, -1, 4'b0000, -1, 4'b0010, 4'b0010, -1};
      run("relb on", v);
      v = '{4'b1111, 30, 4'b0000, 2'd0, -1, -1, -1, 4'b0010, 18, 4'b0010, 4'b0000, 18};
      run("relb rel", v);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
